mf_disp_hs_tx: RTL

MF_DISP_HS_TX -- requirements
Module: mf_disp_hs_tx

---
 rtl/mf_disp_hs_tx.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mf_disp_hs_tx.sv
// mf_disp_hs_tx
// Transmit side of a 4-phase req/ack handshake that moves one DATA_W word
// from the clk_a domain toward a clk_b peer.
//
// Ports
//   clk_a     in   single clock, all state on rising edge
//   resetn    in   synchronous, active-low reset
//   in_valid  in   source offers in_data
//   in_data   in   word to transfer (DATA_W)
//   in_ready  out  word is accepted this cycle when in_valid is also high
//   req_b     out  registered request toward clk_b
//   data_b    out  registered data toward clk_b, held from accept to next accept
//   ack_b     in   acknowledge from clk_b (asynchronous to clk_a)
//   done      out  one-cycle pulse when a transfer completes
//   err       out  sticky timeout flag
//   err_clr   in   clears err on the next edge (a simultaneous timeout wins)
module mf_disp_hs_tx #(
  parameter int DATA_W = 16,
  parameter int TO_W   = 8
) (
  input  logic              clk_a,
  input  logic              resetn,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              req_b,
  output logic [DATA_W-1:0] data_b,
  input  logic              ack_b,
  output logic              done,
  output logic              err,
  input  logic              err_clr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam logic [TO_W-1:0] CNT_ONE = {{(TO_W-1){1'b0}}, 1'b1};
  localparam logic [TO_W-1:0] CNT_MAX = {TO_W{1'b1}};
  // Value from which one more increment saturates the counter.
  localparam logic [TO_W-1:0] CNT_PRE = CNT_MAX - CNT_ONE;

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic              to_hit;
  logic              accept;

  (* ASYNC_REG = "TRUE" *) logic ack_s1_q;
  (* ASYNC_REG = "TRUE" *) logic ack_s2_q;

  // The synchronizer flops clear in reset, so for the first two edges after
  // reset ack_s2 reads 0 regardless of the peer. warm_q marks when ack_s2
  // really reflects ack_b again, so a stale ack from a peer that was not
  // reset cannot let a new word in.
  logic [1:0] warm_q;

  always_ff @(posedge clk_a) begin
    if (!resetn) begin
      ack_s1_q <= 1'b0;
      ack_s2_q <= 1'b0;
      warm_q   <= 2'b00;
    end else begin
      ack_s1_q <= ack_b;
      ack_s2_q <= ack_s1_q;
      warm_q   <= {warm_q[0], 1'b1};
    end
  end

  assign in_ready = (state_q == IDLE) && !ack_s2_q && warm_q[1] && resetn;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    to_hit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = REQ;
          req_d   = 1'b1;
          data_d  = in_data;
          cnt_d   = '0;
        end
      end
      REQ: begin
        if (ack_s2_q) begin
          state_d = DROP;
          req_d   = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d  = cnt_q + CNT_ONE;
          to_hit = (cnt_q == CNT_PRE);
        end
      end
      DROP: begin
        if (!ack_s2_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d  = cnt_q + CNT_ONE;
          to_hit = (cnt_q == CNT_PRE);
        end
      end
      default: state_d = IDLE;
    endcase

    // Timeout only flags; the handshake keeps waiting for the peer.
    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    if (to_hit)  err_d = 1'b1;
  end

  always_ff @(posedge clk_a) begin
    if (!resetn) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_b  = req_q;
  assign data_b = data_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule
